// File: rtl/pwm_duty_meter_pkg.sv
// Shared definitions for the PWM duty meter and its iterative divider.
// Holds the default widths, the saturated duty code and the FSM state type.
package pwm_pkg;

   localparam int PWM_CNT_W  = 20;
   localparam int PWM_DUTY_W = 4;
   localparam int DUTY_MAX   = (1 << PWM_DUTY_W) - 1;

   typedef enum logic {
      IDLE = 1'b0,
      MEAS = 1'b1
   } meas_state_e;

endpackage

// File: rtl/pwm_duty_meter_div.sv
// Iterative restoring divider producing one quotient bit per clock.
// The caller guarantees num < den * 2^Q_W, so only the low Q_W quotient
// bits are computed. The remainder is seeded with num >> Q_W, and the low
// Q_W numerator bits are shifted in one per iteration. done_o and quot_o
// are valid together in the last busy cycle, so a registered consumer sees
// the result on the edge that ends the divide.
module pwm_div #(
   parameter int NUM_W = 24,
   parameter int DEN_W = 20,
   parameter int Q_W   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [NUM_W-1:0] num_i,
   input  logic [DEN_W-1:0] den_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [Q_W-1:0]   quot_o
);

   localparam int CW = $clog2(Q_W + 1);

   logic             busy_q;
   logic [CW-1:0]    cnt_q;
   logic [DEN_W-1:0] rem_q;
   logic [DEN_W-1:0] den_q;
   logic [Q_W-1:0]   low_q;
   logic [Q_W-1:0]   quot_q;

   logic [DEN_W:0]   trial_d;
   logic             ge_d;
   logic [DEN_W-1:0] rem_d;
   logic [Q_W-1:0]   quot_d;

   // One restoring step: shift in the next numerator bit and subtract the
   // divisor whenever the partial remainder is large enough.
   always_comb begin
      trial_d = {rem_q, low_q[Q_W-1]};
      ge_d    = (trial_d >= {1'b0, den_q});
      rem_d   = ge_d ? DEN_W'(trial_d - {1'b0, den_q}) : DEN_W'(trial_d);
      quot_d  = {quot_q[Q_W-2:0], ge_d};
   end

   assign busy_o = busy_q;
   assign done_o = busy_q && (cnt_q == CW'(1));
   assign quot_o = quot_d;

   // Load operands on start, then run Q_W iterations and drop busy
   // after the last one; a start request while busy is ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         rem_q  <= '0;
         den_q  <= '0;
         low_q  <= '0;
         quot_q <= '0;
      end else if (!busy_q && start_i) begin
         busy_q <= 1'b1;
         cnt_q  <= CW'(Q_W);
         rem_q  <= DEN_W'(num_i >> Q_W);
         low_q  <= num_i[Q_W-1:0];
         den_q  <= den_i;
         quot_q <= '0;
      end else if (busy_q) begin
         rem_q  <= rem_d;
         quot_q <= quot_d;
         low_q  <= {low_q[Q_W-2:0], 1'b0};
         cnt_q  <= cnt_q - 1'b1;
         if (cnt_q == CW'(1)) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/pwm_duty_meter.sv
// PWM receiver: synchronises an asynchronous PWM input, measures high time
// and period between consecutive rising edges, and reports the duty cycle on
// a DUTY_W-bit scale. If the input shows no edge for TIMEOUT cycles, it is
// reported as stuck at its current level.
module pwm_duty_meter
   import pwm_pkg::*;
#(
   parameter int CNT_W   = PWM_CNT_W,
   parameter int DUTY_W  = PWM_DUTY_W,
   parameter int TIMEOUT = 2**19
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pwm_in,
   output logic [DUTY_W-1:0] duty,
   output logic [CNT_W-1:0]  period,
   output logic [CNT_W-1:0]  high_time,
   output logic              duty_valid,
   output logic              stuck,
   output logic              overrun
);

   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_SAT  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [DUTY_W-1:0] DUTY_SAT = {DUTY_W{1'b1}};

   logic sync1_q;
   logic sync2_q;
   logic sDly_q;
   logic s;
   logic rise;
   logic fall;

   meas_state_e      state_q, state_d;
   logic [CNT_W-1:0] hiCnt_q, hiCnt_d;
   logic [CNT_W-1:0] perCnt_q, perCnt_d;
   logic [CNT_W-1:0] idleCnt_q, idleCnt_d;
   logic             launch;
   logic             timeoutHit;

   logic [CNT_W-1:0] holdH_q;
   logic [CNT_W-1:0] holdP_q;

   logic [DUTY_W-1:0] duty_q;
   logic [CNT_W-1:0]  period_q;
   logic [CNT_W-1:0]  highTime_q;
   logic              valid_q;
   logic              stuck_q;
   logic              overrun_q;

   logic              divStart;
   logic              divDrop;
   logic              divBusy;
   logic              divDone;
   logic [DUTY_W:0]   divQuot;
   logic [DUTY_W-1:0] divDuty;

   // Two-flop synchroniser followed by a previous-level flop for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sDly_q  <= 1'b0;
      end else begin
         sync1_q <= pwm_in;
         sync2_q <= sync1_q;
         sDly_q  <= sync2_q;
      end
   end

   assign s    = sync2_q;
   assign rise = s & ~sDly_q;
   assign fall = ~s & sDly_q;

   // Next-state logic: the FSM arms on the first rise, then each later rise
   // closes one measurement and restarts the counters. The idle counter
   // watches for a stuck input in both states.
   always_comb begin
      state_d    = state_q;
      hiCnt_d    = hiCnt_q;
      perCnt_d   = perCnt_q;
      idleCnt_d  = idleCnt_q;
      launch     = 1'b0;
      timeoutHit = 1'b0;

      if (rise || fall) begin
         idleCnt_d = '0;
      end else if (idleCnt_q == TO_LAST) begin
         timeoutHit = 1'b1;
         idleCnt_d  = '0;
      end else begin
         idleCnt_d = idleCnt_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (rise) begin
               hiCnt_d  = CNT_ONE;
               perCnt_d = CNT_ONE;
               state_d  = MEAS;
            end
         end
         MEAS: begin
            if (rise) begin
               launch   = 1'b1;
               hiCnt_d  = CNT_ONE;
               perCnt_d = CNT_ONE;
            end else begin
               if (perCnt_q != CNT_SAT) begin
                  perCnt_d = perCnt_q + 1'b1;
               end
               if (s && (hiCnt_q != CNT_SAT)) begin
                  hiCnt_d = hiCnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (timeoutHit) begin
         state_d = IDLE;
      end
   end

   // State and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         hiCnt_q   <= '0;
         perCnt_q  <= '0;
         idleCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         hiCnt_q   <= hiCnt_d;
         perCnt_q  <= perCnt_d;
         idleCnt_q <= idleCnt_d;
      end
   end

   assign divStart = launch && !divBusy;
   assign divDrop  = launch && divBusy;

   pwm_div #(
      .NUM_W (CNT_W + DUTY_W),
      .DEN_W (CNT_W),
      .Q_W   (DUTY_W + 1)
   ) u_div (
      .clk     (clk),
      .rst     (rst),
      .start_i (divStart),
      .num_i   ({hiCnt_q, {DUTY_W{1'b0}}}),
      .den_i   (perCnt_q),
      .busy_o  (divBusy),
      .done_o  (divDone),
      .quot_o  (divQuot)
   );

   assign divDuty = divQuot[DUTY_W] ? DUTY_SAT : divQuot[DUTY_W-1:0];

   // Capture the raw high time and period of the measurement being divided,
   // so they can be reported alongside its duty result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         holdH_q <= '0;
         holdP_q <= '0;
      end else if (divStart) begin
         holdH_q <= hiCnt_q;
         holdP_q <= perCnt_q;
      end
   end

   // Result registers. A finished divide takes priority over a timeout landing
   // in the same cycle. Dropped measurements only raise overrun.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         duty_q     <= '0;
         period_q   <= '0;
         highTime_q <= '0;
         valid_q    <= 1'b0;
         stuck_q    <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         valid_q   <= 1'b0;
         overrun_q <= divDrop;
         if (divDone) begin
            duty_q     <= divDuty;
            period_q   <= holdP_q;
            highTime_q <= holdH_q;
            stuck_q    <= 1'b0;
            valid_q    <= 1'b1;
         end else if (timeoutHit) begin
            duty_q     <= s ? DUTY_SAT : '0;
            period_q   <= '0;
            highTime_q <= '0;
            stuck_q    <= 1'b1;
            valid_q    <= 1'b1;
         end
      end
   end

   assign duty       = duty_q;
   assign period     = period_q;
   assign high_time  = highTime_q;
   assign duty_valid = valid_q;
   assign stuck      = stuck_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Testbench for pwm_duty_meter. PWM waveforms are driven cycle by cycle, and
// every duty_valid pulse and overrun pulse is recorded. The recorded results
// are then compared with expectations built from the input waveform:
// the duty formula, the edge and divider latencies, the divider busy window
// and the timeout interval.
module tb_pwm_duty_meter;

   localparam int CNT_W    = 20;
   localparam int DUTY_W   = 4;
   localparam int TIMEOUT  = 100;
   localparam int EDGE_LAT = 3;
   localparam int DIV_LAT  = DUTY_W + 1;
   localparam int LAT      = EDGE_LAT + DIV_LAT;
   localparam int FULL     = 1 << DUTY_W;

   typedef struct {
      int cyc;
      int duty;
      int per;
      int hi;
      int stk;
   } res_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              pwm_in;
   logic [DUTY_W-1:0] duty;
   logic [CNT_W-1:0]  period;
   logic [CNT_W-1:0]  high_time;
   logic              duty_valid;
   logic              stuck;
   logic              overrun;

   res_t obsQ[$];
   res_t expQ[$];
   int   cycle    = 0;
   int   lastEdge = 0;
   int   lastAcc  = -1000;
   int   ovrCnt   = 0;
   int   expOvr   = 0;
   int   passCnt  = 0;
   int   totalCnt = 0;

   always #5 clk = ~clk;

   pwm_duty_meter #(
      .CNT_W   (CNT_W),
      .DUTY_W  (DUTY_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pwm_in     (pwm_in),
      .duty       (duty),
      .period     (period),
      .high_time  (high_time),
      .duty_valid (duty_valid),
      .stuck      (stuck),
      .overrun    (overrun)
   );

   function automatic int expDuty(int hi, int per);
      int q;
      q = (hi * FULL) / per;
      return (q >= FULL) ? FULL - 1 : q;
   endfunction

   task automatic checkOutput(input string tag, input int obs, input int exp);
      totalCnt++;
      assert (obs === exp) passCnt++;
      else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      res_t r;
      @(posedge clk);
      #1;
      cycle++;
      if (duty_valid === 1'b1) begin
         r.cyc  = cycle;
         r.duty = int'(duty);
         r.per  = int'(period);
         r.hi   = int'(high_time);
         r.stk  = int'(stuck);
         obsQ.push_back(r);
      end
      if (overrun === 1'b1) ovrCnt++;
   endtask

   task automatic setPwm(input logic v);
      if (v !== pwm_in) lastEdge = cycle;
      pwm_in = v;
   endtask

   task automatic pushExp(input int cyc, input int d, input int per, input int hi, input int stk);
      res_t r;
      r.cyc  = cyc;
      r.duty = d;
      r.per  = per;
      r.hi   = hi;
      r.stk  = stk;
      expQ.push_back(r);
   endtask

   task automatic doReset(input logic lvl);
      pwm_in = lvl;
      rst    = 1'b1;
      #1;
      checkOutput("rst.duty", int'(duty), 0);
      checkOutput("rst.period", int'(period), 0);
      checkOutput("rst.high_time", int'(high_time), 0);
      checkOutput("rst.duty_valid", int'(duty_valid), 0);
      checkOutput("rst.stuck", int'(stuck), 0);
      checkOutput("rst.overrun", int'(overrun), 0);
      repeat (3) tick();
      rst      = 1'b0;
      lastEdge = cycle;
      lastAcc  = -1000;
   endtask

   // n periods starting from an armed-idle meter: the first rise only arms,
   // every later rise closes a period; rises closer than the divider busy
   // window to the last accepted one are dropped as overruns.
   task automatic applyStimulus(input int hi, input int per, input int n);
      lastAcc = -1000;
      for (int p = 0; p < n; p++) begin
         for (int c = 0; c < per; c++) begin
            setPwm(c < hi);
            if (c == 0 && p > 0) begin
               if (cycle - lastAcc > DIV_LAT) begin
                  pushExp(cycle + LAT, expDuty(hi, per), per, hi, 0);
                  lastAcc = cycle;
               end else begin
                  expOvr++;
               end
            end
            tick();
         end
      end
   endtask

   // Hold a constant level; the stuck report recurs every TIMEOUT cycles
   // after the last edge has passed the synchroniser.
   task automatic holdLevel(input logic v, input int len);
      int c0;
      int endCyc;
      setPwm(v);
      c0     = cycle;
      endCyc = cycle + len;
      for (int t = 1; lastEdge + EDGE_LAT + TIMEOUT * t <= endCyc; t++) begin
         if (lastEdge + EDGE_LAT + TIMEOUT * t > c0)
            pushExp(lastEdge + EDGE_LAT + TIMEOUT * t, v ? FULL - 1 : 0, 0, 0, 1);
      end
      repeat (len) tick();
   endtask

   task automatic checkQueues(input string name);
      int n;
      checkOutput({name, ".count"}, obsQ.size(), expQ.size());
      n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
      for (int i = 0; i < n; i++) begin
         checkOutput($sformatf("%s[%0d].cycle", name, i), obsQ[i].cyc, expQ[i].cyc);
         checkOutput($sformatf("%s[%0d].duty", name, i), obsQ[i].duty, expQ[i].duty);
         checkOutput($sformatf("%s[%0d].period", name, i), obsQ[i].per, expQ[i].per);
         checkOutput($sformatf("%s[%0d].high", name, i), obsQ[i].hi, expQ[i].hi);
         checkOutput($sformatf("%s[%0d].stuck", name, i), obsQ[i].stk, expQ[i].stk);
      end
      checkOutput({name, ".overruns"}, ovrCnt, expOvr);
      obsQ.delete();
      expQ.delete();
      ovrCnt = 0;
      expOvr = 0;
   endtask

   initial begin
      int rp;
      int rh;
      int rn;

      $display("[TB] start");
      doReset(1'b0);

      applyStimulus(4, 16, 4);
      holdLevel(1'b0, TIMEOUT + 20);
      checkQueues("p16h4");

      applyStimulus(63, 64, 3);
      holdLevel(1'b0, TIMEOUT + 10);
      checkQueues("p64h63");

      applyStimulus(98, 99, 3);
      holdLevel(1'b0, TIMEOUT + 10);
      checkQueues("p99h98");

      doReset(1'b1);
      holdLevel(1'b1, 2 * TIMEOUT + 10);
      holdLevel(1'b0, TIMEOUT + 10);
      applyStimulus(10, 20, 3);
      holdLevel(1'b0, TIMEOUT + 10);
      checkQueues("stuck");

      applyStimulus(2, 4, 10);
      holdLevel(1'b0, TIMEOUT + 10);
      checkQueues("overrun");

      for (int k = 0; k < 4; k++) begin
         rp = $urandom_range(90, 8);
         rh = $urandom_range(rp - 1, 1);
         rn = $urandom_range(5, 3);
         applyStimulus(rh, rp, rn);
         holdLevel(1'b0, TIMEOUT + 5);
         checkQueues($sformatf("rand%0d_p%0dh%0d", k, rp, rh));
      end

      applyStimulus(4, 16, 3);
      setPwm(1'b1);
      tick();
      for (int c = 1; c < 6; c++) begin
         setPwm(c < 4);
         tick();
      end
      checkQueues("prerst");
      doReset(1'b0);
      applyStimulus(10, 20, 3);
      holdLevel(1'b0, TIMEOUT + 10);
      checkQueues("postrst");

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
